// File: rtl/swervolf_bist_pkg.sv
// Shared constants and the address-derived test pattern for the AXI RAM self-test.
package swervolf_bist_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_ADDR  = 3'd1;
  localparam logic [2:0] S_WR_DATA  = 3'd2;
  localparam logic [2:0] S_WR_RESP  = 3'd3;
  localparam logic [2:0] S_RD_ADDR  = 3'd4;
  localparam logic [2:0] S_RD_DATA  = 3'd5;
  localparam logic [2:0] S_RD_DRAIN = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Upper word is the inverted address so stuck-at and aliasing faults both show up.
  function automatic logic [63:0] bist_pattern(input logic [31:0] addr);
    return {~addr, addr};
  endfunction

endpackage

// File: rtl/swervolf_axi_mem_bist.sv
// AXI4 initiator that fills the RAM with an address pattern in INCR bursts, reads it back,
// and reports pass/fail plus the first failing byte address.
module swervolf_axi_mem_bist
  import swervolf_bist_pkg::*;
#(
  parameter int          ID_WIDTH  = 6,
  parameter logic [31:0] MEM_SIZE  = 32'h10000,
  parameter int          BURST_LEN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [31:0]         o_err_addr,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  output logic [ID_WIDTH-1:0] o_arid,
  output logic [31:0]         o_araddr,
  output logic [7:0]          o_arlen,
  output logic [2:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [ID_WIDTH-1:0] i_rid,
  input  logic [63:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready
);

  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);
  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  beat_q, beat_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic [63:0] wdata_q, wdata_d;
  logic        wlast_q, wlast_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic [31:0] next_base;
  logic        rd_last_beat;
  logic        rd_bad;

  assign next_base    = base_q + BURST_BYTES;
  assign rd_last_beat = (beat_q == LAST_BEAT);
  // rlast must appear exactly on the final beat; anything else is a protocol fault.
  assign rd_bad = (i_rresp != AXI_RESP_OKAY) || (i_rid != '0) ||
                  (i_rdata != bist_pattern(addr_q)) || (i_rlast != rd_last_beat);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    wdata_d    = wdata_q;
    wlast_d    = wlast_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_addr_d = err_addr_q;
    case (state_q)
      S_IDLE, S_DONE: if (i_start) begin
        state_d    = S_WR_ADDR;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        pass_d     = 1'b0;
        err_addr_d = '0;
        base_d     = '0;
        awvalid_d  = 1'b1;
      end
      S_WR_ADDR: if (i_awready) begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b1;
        addr_d    = base_q;
        beat_d    = '0;
        wdata_d   = bist_pattern(base_q);
        wlast_d   = (LAST_BEAT == 8'd0);
        state_d   = S_WR_DATA;
      end
      S_WR_DATA: if (i_wready) begin
        if (wlast_q) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end else begin
          beat_d  = beat_q + 8'd1;
          addr_d  = addr_q + 32'd8;
          wdata_d = bist_pattern(addr_q + 32'd8);
          wlast_d = ((beat_q + 8'd1) == LAST_BEAT);
        end
      end
      S_WR_RESP: if (i_bvalid) begin
        bready_d = 1'b0;
        if ((i_bresp != AXI_RESP_OKAY) || (i_bid != '0)) begin
          err_addr_d = base_q;
          state_d    = S_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else if (next_base >= MEM_SIZE) begin
          base_d    = '0;
          arvalid_d = 1'b1;
          state_d   = S_RD_ADDR;
        end else begin
          base_d    = next_base;
          awvalid_d = 1'b1;
          state_d   = S_WR_ADDR;
        end
      end
      S_RD_ADDR: if (i_arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        addr_d    = base_q;
        beat_d    = '0;
        state_d   = S_RD_DATA;
      end
      S_RD_DATA: if (i_rvalid) begin
        if (rd_bad) begin
          err_addr_d = addr_q;
          beat_d     = beat_q + 8'd1;
          if (i_rlast || rd_last_beat) begin
            rready_d = 1'b0;
            state_d  = S_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            state_d = S_RD_DRAIN;
          end
        end else if (rd_last_beat) begin
          rready_d = 1'b0;
          if (next_base >= MEM_SIZE) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            base_d    = next_base;
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end else begin
          beat_d = beat_q + 8'd1;
          addr_d = addr_q + 32'd8;
        end
      end
      S_RD_DRAIN: if (i_rvalid) begin
        // Swallow the rest of the failed burst so the responder is left idle.
        beat_d = beat_q + 8'd1;
        if (i_rlast || rd_last_beat) begin
          rready_d = 1'b0;
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      beat_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wdata_q    <= '0;
      wlast_q    <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      wdata_q    <= wdata_d;
      wlast_q    <= wlast_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_pass     = pass_q;
  assign o_err_addr = err_addr_q;

  assign o_awid    = '0;
  assign o_awaddr  = base_q;
  assign o_awlen   = LAST_BEAT;
  assign o_awsize  = AXI_SIZE_8B;
  assign o_awburst = AXI_BURST_INCR;
  assign o_awvalid = awvalid_q;

  assign o_wdata  = wdata_q;
  assign o_wstrb  = 8'hFF;
  assign o_wlast  = wlast_q;
  assign o_wvalid = wvalid_q;
  assign o_bready = bready_q;

  assign o_arid    = '0;
  assign o_araddr  = base_q;
  assign o_arlen   = LAST_BEAT;
  assign o_arsize  = AXI_SIZE_8B;
  assign o_arburst = AXI_BURST_INCR;
  assign o_arvalid = arvalid_q;
  assign o_rready  = rready_q;

endmodule

// File: tb/tb_swervolf_axi_mem_bist.sv
// Bench for swervolf_axi_mem_bist: AXI RAM model with stall/error injection and a transaction scoreboard.
module tb_swervolf_axi_mem_bist;

  localparam int BL = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic i_start;
  logic o_busy, o_done, o_pass;
  logic [31:0] o_err_addr;
  logic [5:0] o_awid, o_arid, i_bid, i_rid;
  logic [31:0] o_awaddr, o_araddr;
  logic [7:0] o_awlen, o_arlen, o_wstrb;
  logic [2:0] o_awsize, o_arsize;
  logic [1:0] o_awburst, o_arburst, i_bresp, i_rresp;
  logic o_awvalid, i_awready, o_wlast, o_wvalid, i_wready, i_bvalid, o_bready;
  logic o_arvalid, i_arready, i_rlast, i_rvalid, o_rready;
  logic [63:0] o_wdata, i_rdata;

  swervolf_axi_mem_bist #(.ID_WIDTH(6), .MEM_SIZE(32'h100), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_err_addr(o_err_addr),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          stall;
    logic [31:0] bad_addr;   // read data corrupted at this address
    int          berr_burst; // write burst index answered with SLVERR, -1 none
    int          n_aw;
    int          n_ar;
    bit          exp_pass;
    logic [31:0] exp_err;
  } tc_t;

  typedef struct packed { logic [63:0] d; logic l; } wexp_t;
  typedef struct packed { logic [31:0] a; logic l; } rbeat_t;

  tc_t tbl[4];
  tc_t tc;
  int n_cmp = 0, n_bad = 0;

  logic [31:0] exp_aw_q[$], exp_ar_q[$];
  wexp_t       w_q[$];
  logic [1:0]  b_q[$];
  rbeat_t      r_q[$];
  logic [63:0] mem [0:31];
  int          n_aw_seen, n_ar_seen, wr_burst;
  logic [31:0] wr_addr;
  logic [63:0] first_wdata;
  bit          got_first;

  bit hs_aw, hs_w, hs_b, hs_ar, hs_r, st_aw, st_w, st_ar;
  logic [31:0] s_awaddr, s_araddr;
  logic [7:0]  s_awlen, s_arlen, s_wstrb;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_arburst;
  logic [5:0]  s_awid, s_arid;
  logic [63:0] s_wdata;
  logic        s_wlast;

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string act, input string exp);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %s expected %s", name, act, exp);
  endtask

  // AXI responder + scoreboard: handshakes captured at one negedge take effect at the next posedge
  // and are retired at the following negedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      {hs_aw, hs_w, hs_b, hs_ar, hs_r, st_aw, st_w, st_ar} = '0;
      i_awready = 0; i_wready = 0; i_arready = 0;
      i_bvalid = 0; i_bid = 0; i_bresp = 0;
      i_rvalid = 0; i_rid = 0; i_rdata = 0; i_rresp = 0; i_rlast = 0;
      w_q.delete(); b_q.delete(); r_q.delete();
    end else begin
      if (st_aw) begin chk("aw_hold", o_awvalid, 1); chk("aw_stable", o_awaddr, s_awaddr); end
      if (st_w) begin
        chk("w_hold", o_wvalid, 1); chk("w_data_stable", o_wdata, s_wdata); chk("w_last_stable", o_wlast, s_wlast);
      end
      if (st_ar) begin chk("ar_hold", o_arvalid, 1); chk("ar_stable", o_araddr, s_araddr); end

      if (hs_aw) begin
        n_aw_seen++;
        if (exp_aw_q.size() == 0) fail("aw_unexpected", $sformatf("awaddr %h", s_awaddr), "no AW");
        else begin
          logic [31:0] ea;
          ea = exp_aw_q.pop_front();
          chk("aw_addr", s_awaddr, ea); chk("aw_len", s_awlen, BL - 1); chk("aw_size", s_awsize, 3);
          chk("aw_burst", s_awburst, 1); chk("aw_id", s_awid, 0);
          for (int b = 0; b < BL; b++) w_q.push_back('{d: pat(ea + 32'(b * 8)), l: (b == BL - 1)});
          wr_addr = ea;
        end
      end
      if (hs_w) begin
        if (w_q.size() == 0) fail("w_unexpected", $sformatf("wdata %h", s_wdata), "no W beat");
        else begin
          wexp_t e;
          e = w_q.pop_front();
          chk("w_data", s_wdata, e.d); chk("w_last", s_wlast, e.l); chk("w_strb", s_wstrb, 8'hFF);
          if (!got_first) begin first_wdata = s_wdata; got_first = 1; end
          mem[wr_addr[7:3]] = s_wdata;
          wr_addr += 8;
          if (s_wlast) begin
            b_q.push_back(wr_burst == tc.berr_burst ? 2'b10 : 2'b00);
            wr_burst++;
          end
        end
      end
      if (hs_b) void'(b_q.pop_front());
      if (hs_ar) begin
        n_ar_seen++;
        if (exp_ar_q.size() == 0) fail("ar_unexpected", $sformatf("araddr %h", s_araddr), "no AR");
        else begin
          logic [31:0] ea;
          ea = exp_ar_q.pop_front();
          chk("ar_addr", s_araddr, ea); chk("ar_len", s_arlen, BL - 1); chk("ar_size", s_arsize, 3);
          chk("ar_burst", s_arburst, 1); chk("ar_id", s_arid, 0);
        end
        for (int b = 0; b < BL; b++) r_q.push_back('{a: s_araddr + 32'(b * 8), l: (b == BL - 1)});
      end
      if (hs_r) void'(r_q.pop_front());

      i_awready = tc.stall ? 1'($urandom_range(1, 0)) : 1'b1;
      i_wready  = tc.stall ? 1'($urandom_range(1, 0)) : 1'b1;
      i_arready = tc.stall ? 1'($urandom_range(1, 0)) : 1'b1;
      if (!(i_bvalid && !hs_b)) begin
        i_bvalid = (b_q.size() > 0) && (!tc.stall || 1'($urandom_range(1, 0)));
        i_bresp  = i_bvalid ? b_q[0] : 2'b00;
      end
      if (!(i_rvalid && !hs_r)) begin
        i_rvalid = (r_q.size() > 0) && (!tc.stall || 1'($urandom_range(1, 0)));
        if (i_rvalid) begin
          i_rdata = mem[r_q[0].a[7:3]] ^ ((r_q[0].a == tc.bad_addr) ? 64'h1 : 64'h0);
          i_rlast = r_q[0].l;
        end else begin
          i_rdata = 0; i_rlast = 0;
        end
      end

      hs_aw = o_awvalid && i_awready;  st_aw = o_awvalid && !i_awready;
      hs_w  = o_wvalid && i_wready;    st_w  = o_wvalid && !i_wready;
      hs_ar = o_arvalid && i_arready;  st_ar = o_arvalid && !i_arready;
      hs_b  = o_bready && i_bvalid;
      hs_r  = o_rready && i_rvalid;
      s_awaddr = o_awaddr; s_awlen = o_awlen; s_awsize = o_awsize; s_awburst = o_awburst; s_awid = o_awid;
      s_wdata = o_wdata; s_wlast = o_wlast; s_wstrb = o_wstrb;
      s_araddr = o_araddr; s_arlen = o_arlen; s_arsize = o_arsize; s_arburst = o_arburst; s_arid = o_arid;
    end
  end

  task automatic setup(input tc_t t);
    @(negedge clk); #2;
    tc = t;
    exp_aw_q.delete(); exp_ar_q.delete();
    for (int i = 0; i < t.n_aw; i++) exp_aw_q.push_back(32'(i * 64));
    for (int i = 0; i < t.n_ar; i++) exp_ar_q.push_back(32'(i * 64));
    n_aw_seen = 0; n_ar_seen = 0; wr_burst = 0; got_first = 0;
  endtask

  task automatic start_pulse();
    @(negedge clk); i_start = 1;
    @(negedge clk); i_start = 0;
    chk("start_busy", o_busy, 1); chk("start_done", o_done, 0); chk("start_pass", o_pass, 0);
    chk("start_err", o_err_addr, 0); chk("start_awvalid", o_awvalid, 1); chk("start_awaddr", o_awaddr, 0);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!o_done && k < 4000) begin @(negedge clk); k++; end
    if (!o_done) fail(name, "no done", "done within 4000 cycles");
  endtask

  task automatic finish_check(input string name, input tc_t t);
    repeat (10) @(negedge clk);
    chk({name, "_done"}, o_done, 1); chk({name, "_busy"}, o_busy, 0);
    chk({name, "_pass"}, o_pass, t.exp_pass); chk({name, "_err_addr"}, o_err_addr, t.exp_err);
    chk({name, "_n_aw"}, 64'(n_aw_seen), 64'(t.n_aw)); chk({name, "_n_ar"}, 64'(n_ar_seen), 64'(t.n_ar));
    chk({name, "_w_left"}, 64'(w_q.size()), 0); chk({name, "_r_left"}, 64'(r_q.size()), 0);
  endtask

  initial begin
    tbl[0] = '{stall: 0, bad_addr: 32'hFFFF_FFFF, berr_burst: -1, n_aw: 4, n_ar: 4, exp_pass: 1, exp_err: 32'h0};
    tbl[1] = '{stall: 0, bad_addr: 32'h48,        berr_burst: -1, n_aw: 4, n_ar: 2, exp_pass: 0, exp_err: 32'h48};
    tbl[2] = '{stall: 0, bad_addr: 32'hFFFF_FFFF, berr_burst: 1,  n_aw: 2, n_ar: 0, exp_pass: 0, exp_err: 32'h40};
    tbl[3] = '{stall: 1, bad_addr: 32'hFFFF_FFFF, berr_burst: -1, n_aw: 4, n_ar: 4, exp_pass: 1, exp_err: 32'h0};
    tc = tbl[0];
    rst_n = 0; i_start = 0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", o_awvalid, 0); chk("rst_wvalid", o_wvalid, 0); chk("rst_bready", o_bready, 0);
    chk("rst_arvalid", o_arvalid, 0); chk("rst_rready", o_rready, 0); chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0); chk("rst_pass", o_pass, 0); chk("rst_err", o_err_addr, 0);
    #2 rst_n = 1;

    for (int i = 0; i < 4; i++) begin
      setup(tbl[i]);
      start_pulse();
      wait_done($sformatf("t%0d_timeout", i));
      finish_check($sformatf("t%0d", i), tbl[i]);
      if (i == 0) chk("first_wdata", first_wdata, 64'hFFFFFFFF_00000000);
    end

    // Reset in the middle of the read phase.
    setup(tbl[0]);
    start_pulse();
    begin
      int k;
      k = 0;
      while (!o_rready && k < 4000) begin @(negedge clk); k++; end
      if (!o_rready) fail("rd_phase_timeout", "no rready", "rready within 4000 cycles");
    end
    #2 rst_n = 0;
    #1;
    chk("mid_rst_awvalid", o_awvalid, 0); chk("mid_rst_wvalid", o_wvalid, 0); chk("mid_rst_bready", o_bready, 0);
    chk("mid_rst_arvalid", o_arvalid, 0); chk("mid_rst_rready", o_rready, 0); chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_done", o_done, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    setup(tbl[0]);
    start_pulse();
    wait_done("t5_timeout");
    finish_check("t5", tbl[0]);

    // Start while busy is ignored; start while done begins a fresh run.
    setup(tbl[0]);
    start_pulse();
    repeat (20) @(negedge clk);
    i_start = 1;
    @(negedge clk); i_start = 0;
    chk("busy_start_busy", o_busy, 1); chk("busy_start_done", o_done, 0);
    wait_done("t6a_timeout");
    finish_check("t6a", tbl[0]);
    setup(tbl[0]);
    start_pulse();
    wait_done("t6b_timeout");
    finish_check("t6b", tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
